// File: rtl/fifo_sync_param_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync_param_pkg : read-mode constants and config range checks |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fifo_sync_param_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int MIN_ADDR_WIDTH = 2;
  localparam int MAX_ADDR_WIDTH = 10;

  function automatic bit depth_ok(input int addr_width);
    return (addr_width >= MIN_ADDR_WIDTH) && (addr_width <= MAX_ADDR_WIDTH);
  endfunction

  function automatic bit levels_ok(input int addr_width, input int af_level, input int ae_level);
    int depth;
    depth = 1 << addr_width;
    return (af_level >= 1) && (af_level <= depth) && (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_param_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync_param_if : producer/consumer bundle of the FIFO         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  flush;
  logic                  clr_err;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, push_data, pop, flush, clr_err,
    input  pop_data, pop_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, flush, clr_err,
    output pop_data, pop_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_param_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync_param_mem : DEPTH x DATA_WIDTH regfile, sync wr/async rd |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_sync_param_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic                  clk,
  input  wire logic                  wr_en,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr,
  output logic      [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // No reset: stale contents are unreachable once the pointers clear.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];
endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync_param : parametrised single-clock FIFO with flags       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 1,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input wire logic         clk,
  input wire logic         rst,
  fifo_sync_param_if.slave bus
);
  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_af_lvl = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_ae_lvl = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_one    = (ADDR_WIDTH+1)'(1);

  if (!depth_ok(ADDR_WIDTH)) begin : g_bad_depth
    $error("fifo_sync_param: ADDR_WIDTH out of range");
  end
  if (!levels_ok(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("fifo_sync_param: AF_LEVEL/AE_LEVEL out of range");
  end
  if (FWFT != FIFO_MODE_FWFT && FWFT != FIFO_MODE_REG) begin : g_bad_mode
    $error("fifo_sync_param: FWFT must be 0 or 1");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  // Flush swallows the whole cycle: no transfer and no error reported.
  assign w_wr_ok   = bus.push & (~w_full | bus.pop) & ~bus.flush;
  assign w_rd_ok   = bus.pop & ~w_empty & ~bus.flush;
  assign w_ovf_set = bus.push & w_full & ~bus.pop & ~bus.flush;
  assign w_unf_set = bus.pop & w_empty & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)        r_overflow  <= 1'b1;
      else if (bus.clr_err) r_overflow  <= 1'b0;
      if (w_unf_set)        r_underflow <= 1'b1;
      else if (bus.clr_err) r_underflow <= 1'b0;
    end
  end

  fifo_sync_param_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_ok),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.push_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_head)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign bus.pop_data  = w_head;
    assign bus.pop_valid = ~w_empty;
  end else begin : g_reg_out
    logic [DATA_WIDTH-1:0] r_pop_data;
    logic                  r_pop_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pop_data  <= '0;
        r_pop_valid <= 1'b0;
      end else if (bus.flush) begin
        r_pop_valid <= 1'b0;
      end else begin
        r_pop_valid <= w_rd_ok;
        if (w_rd_ok) r_pop_data <= w_head;
      end
    end

    assign bus.pop_data  = r_pop_data;
    assign bus.pop_valid = r_pop_valid;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= c_af_lvl);
  assign bus.almost_empty = (r_count <= c_ae_lvl);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_sync_param : directed bench, FWFT and registered variants |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fifo_sync_param;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_f ();
  fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_r ();

  fifo_sync_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)
  ) dut_fwft (.clk(clk), .rst(rst), .bus(bus_f));

  fifo_sync_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)
  ) dut_reg (.clk(clk), .rst(rst), .bus(bus_r));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       push, pop, flush, clr;
    logic [7:0] data;
    logic [4:0] count;
    logic       ovf, unf, chk_head;
    logic [7:0] head;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_f.push = 0; bus_f.pop = 0; bus_f.flush = 0; bus_f.clr_err = 0; bus_f.push_data = '0;
    bus_r.push = 0; bus_r.pop = 0; bus_r.flush = 0; bus_r.clr_err = 0; bus_r.push_data = '0;
  endtask

  // One clock on the FWFT instance; inputs drop back to idle after sampling.
  task automatic step_f(input logic pu, input logic po, input logic fl, input logic cl,
                        input logic [7:0] d);
    @(negedge clk);
    bus_f.push = pu; bus_f.pop = po; bus_f.flush = fl; bus_f.clr_err = cl; bus_f.push_data = d;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic step_r(input logic pu, input logic po, input logic fl, input logic cl,
                        input logic [7:0] d);
    @(negedge clk);
    bus_r.push = pu; bus_r.pop = po; bus_r.flush = fl; bus_r.clr_err = cl; bus_r.push_data = d;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Flags follow from occupancy with AF_LEVEL=12, AE_LEVEL=2, depth 16.
  task automatic status_f(input string tag, input int cnt, input logic ovf, input logic unf);
    chk({tag, " count"},        32'(bus_f.count),        32'(cnt));
    chk({tag, " full"},         32'(bus_f.full),         32'(cnt == 16));
    chk({tag, " empty"},        32'(bus_f.empty),        32'(cnt == 0));
    chk({tag, " almost_full"},  32'(bus_f.almost_full),  32'(cnt >= 12));
    chk({tag, " almost_empty"}, 32'(bus_f.almost_empty), 32'(cnt <= 2));
    chk({tag, " overflow"},     32'(bus_f.overflow),     32'(ovf));
    chk({tag, " underflow"},    32'(bus_f.underflow),    32'(unf));
  endtask

  initial begin
    idle_inputs();

    //            push pop fl clr data   cnt ovf unf chk head
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 5'd0,1'b0,1'b1,1'b0,8'h00};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 5'd0,1'b0,1'b0,1'b0,8'h00};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,8'h11, 5'd1,1'b0,1'b1,1'b1,8'h11};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,8'h00, 5'd0,1'b0,1'b0,1'b0,8'h00};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,8'h00, 5'd0,1'b0,1'b1,1'b0,8'h00};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 5'd0,1'b0,1'b0,1'b0,8'h00};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,8'h21, 5'd1,1'b0,1'b0,1'b1,8'h21};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,8'h22, 5'd2,1'b0,1'b0,1'b1,8'h21};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,8'h23, 5'd3,1'b0,1'b0,1'b1,8'h21};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 5'd2,1'b0,1'b0,1'b1,8'h22};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,8'h24, 5'd2,1'b0,1'b0,1'b1,8'h23};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 5'd1,1'b0,1'b0,1'b1,8'h24};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 5'd0,1'b0,1'b0,1'b0,8'h00};

    // Reset state on both variants
    repeat (2) @(posedge clk);
    #1;
    status_f("reset", 0, 1'b0, 1'b0);
    chk("reset fwft pop_valid", 32'(bus_f.pop_valid), 32'd0);
    chk("reset reg pop_valid",  32'(bus_r.pop_valid), 32'd0);
    chk("reset reg pop_data",   32'(bus_r.pop_data),  32'd0);
    chk("reset reg count",      32'(bus_r.count),     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: error flags, clr_err, simultaneous push/pop at empty, basic order
    for (int v = 0; v < 13; v++) begin
      step_f(vecs[v].push, vecs[v].pop, vecs[v].flush, vecs[v].clr, vecs[v].data);
      status_f($sformatf("vec%0d", v), int'(vecs[v].count), vecs[v].ovf, vecs[v].unf);
      if (vecs[v].chk_head)
        chk($sformatf("vec%0d head", v), 32'(bus_f.pop_data), 32'(vecs[v].head));
    end

    // Fill to full, reject the 17th push, drain in order
    for (int i = 0; i < 16; i++) begin
      step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      status_f($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0);
    end
    step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    status_f("push at full", 16, 1'b1, 1'b0);
    chk("push at full head", 32'(bus_f.pop_data), 32'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d data", i), 32'(bus_f.pop_data), 32'(i));
      step_f(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    status_f("drained", 0, 1'b1, 1'b0);
    step_f(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    status_f("clr overflow", 0, 1'b0, 1'b0);

    // Simultaneous push/pop at full
    for (int i = 0; i < 16; i++) step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h30 + i));
    status_f("refill", 16, 1'b0, 1'b0);
    step_f(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    status_f("push+pop full", 16, 1'b0, 1'b0);
    chk("push+pop full head", 32'(bus_f.pop_data), 32'h31);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sim drain%0d data", i), 32'(bus_f.pop_data),
          (i == 15) ? 32'hAA : 32'(8'h31 + i));
      step_f(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    status_f("sim drained", 0, 1'b0, 1'b0);

    // Wrap: pointers cross 15 -> 0
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + 16 * r + i));
      status_f($sformatf("wrap%0d filled", r), 10, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("wrap%0d data%0d", r, i), 32'(bus_f.pop_data), 32'(8'h40 + 16 * r + i));
        step_f(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      end
      status_f($sformatf("wrap%0d drained", r), 0, 1'b0, 1'b0);
    end

    // Flush at full, and flush with push at count 7
    for (int i = 0; i < 17; i++) step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
    status_f("pre-flush full", 16, 1'b1, 1'b0);
    step_f(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    status_f("flush at full", 0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h70 + i));
    status_f("count 7", 7, 1'b1, 1'b0);
    step_f(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
    status_f("flush+push", 0, 1'b1, 1'b0);
    step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
    status_f("after flush push", 1, 1'b1, 1'b0);
    chk("after flush head", 32'(bus_f.pop_data), 32'h77);

    // Registered-output variant: one-cycle latency, hold, flush
    step_r(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    chk("reg push count",       32'(bus_r.count),     32'd1);
    chk("reg pre-pop valid",    32'(bus_r.pop_valid), 32'd0);
    step_r(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("reg t+1 valid",        32'(bus_r.pop_valid), 32'd1);
    chk("reg t+1 data",         32'(bus_r.pop_data),  32'h5A);
    chk("reg t+1 count",        32'(bus_r.count),     32'd0);
    step_r(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reg t+2 valid",        32'(bus_r.pop_valid), 32'd0);
    chk("reg t+2 data hold",    32'(bus_r.pop_data),  32'h5A);
    step_r(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("reg empty pop valid",  32'(bus_r.pop_valid), 32'd0);
    chk("reg empty underflow",  32'(bus_r.underflow), 32'd1);
    step_r(1'b1, 1'b0, 1'b0, 1'b0, 8'h6B);
    step_r(1'b1, 1'b0, 1'b0, 1'b0, 8'h7C);
    step_r(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("reg b2b 1 valid",      32'(bus_r.pop_valid), 32'd1);
    chk("reg b2b 1 data",       32'(bus_r.pop_data),  32'h6B);
    step_r(1'b1, 1'b1, 1'b0, 1'b0, 8'h8D);
    chk("reg b2b 2 valid",      32'(bus_r.pop_valid), 32'd1);
    chk("reg b2b 2 data",       32'(bus_r.pop_data),  32'h7C);
    step_r(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("reg flush valid",      32'(bus_r.pop_valid), 32'd0);
    chk("reg flush count",      32'(bus_r.count),     32'd0);
    chk("reg flush data hold",  32'(bus_r.pop_data),  32'h7C);
    chk("reg flush underflow",  32'(bus_r.underflow), 32'd1);

    // Asynchronous reset between clock edges with count 5
    for (int i = 0; i < 4; i++) step_f(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
    status_f("pre-reset", 5, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    status_f("async reset", 0, 1'b0, 1'b0);
    chk("async reset reg underflow", 32'(bus_r.underflow), 32'd0);
    chk("async reset reg pop_data",  32'(bus_r.pop_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    step_f(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    status_f("post reset", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
